// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
//   Fractional-N baud tick generator for the UART TX/RX paths.
//   An oversample period lasts DIVxR+1 clock cycles. The accumulator adds
//   FRACxR/2^FRAC_W of a cycle each period, and its carry stretches the next
//   period by one cycle, so the mean period is DIVxR + 1 + FRACxR/2^FRAC_W.
//   Every OSR oversample ticks a bit tick is issued together with the os_tick.
//   Divisor inputs are sampled only on a period boundary, so retuning never
//   produces a short or glitched period.
//
// Ports
//   clk      in   1       system clock, rising edge
//   rst      in   1       synchronous, active-low reset
//   b_en     in   1       1 = run, 0 = hold generator cleared (loads divisors)
//   DIVxR    in   DIV_W   integer divisor, os period = DIVxR+1 cycles
//   FRACxR   in   FRAC_W  fractional divisor added per os period
//   os_tick  out  1       one-cycle oversample tick (registered)
//   b_tick   out  1       one-cycle bit tick, coincident with every OSR-th os_tick
//   os_phase out  PH_W    index of the most recently issued os_tick
// -----------------------------------------------------------------------------
module baud_gen_frac #(
    parameter int  DIV_W  = 16,
    parameter int  FRAC_W = 4,
    parameter int  OSR    = 16,
    localparam int PH_W   = (OSR > 1) ? $clog2(OSR) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b_en,
    input  logic [DIV_W-1:0]  DIVxR,
    input  logic [FRAC_W-1:0] FRACxR,
    output logic              os_tick,
    output logic              b_tick,
    output logic [PH_W-1:0]   os_phase
);

    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
    localparam logic [DIV_W:0]   CNT_ONE = (DIV_W + 1)'(1);

    // The count is one bit wider than the divisor so that a carry-stretched
    // period at DIVxR = 2^DIV_W-1 (limit 2^DIV_W) is still reachable.
    logic [DIV_W:0]      cnt_q, cnt_d;
    logic [FRAC_W-1:0]   acc_q, acc_d;
    logic                carry_q, carry_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [DIV_W-1:0]    div_act_q, div_act_d;
    logic [FRAC_W-1:0]   frac_act_q, frac_act_d;
    logic                os_tick_q, os_tick_d;
    logic                b_tick_q, b_tick_d;
    logic [PH_W-1:0]     os_phase_q, os_phase_d;

    logic [DIV_W:0]      limit;
    logic [FRAC_W:0]     frac_sum;

    assign limit    = {1'b0, div_act_q} + (DIV_W + 1)'(carry_q);
    assign frac_sum = {1'b0, acc_q} + {1'b0, frac_act_q};

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        phase_d    = phase_q;
        div_act_d  = div_act_q;
        frac_act_d = frac_act_q;
        os_tick_d  = 1'b0;
        b_tick_d   = 1'b0;
        os_phase_d = os_phase_q;

        if (!b_en) begin
            // Held cleared, but keep the active divisors tracking the inputs
            // so the first period after enable uses the current settings.
            cnt_d      = '0;
            acc_d      = '0;
            carry_d    = 1'b0;
            phase_d    = '0;
            div_act_d  = DIVxR;
            frac_act_d = FRACxR;
            os_phase_d = '0;
        end else if (cnt_q == limit) begin
            // Period boundary: issue the tick and retune for the next period.
            cnt_d              = '0;
            os_tick_d          = 1'b1;
            {carry_d, acc_d}   = frac_sum;
            div_act_d          = DIVxR;
            frac_act_d         = FRACxR;
            b_tick_d           = (phase_q == PH_LAST);
            os_phase_d         = phase_q;
            phase_d            = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            phase_q    <= '0;
            div_act_q  <= '0;
            frac_act_q <= '0;
            os_tick_q  <= 1'b0;
            b_tick_q   <= 1'b0;
            os_phase_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            phase_q    <= phase_d;
            div_act_q  <= div_act_d;
            frac_act_q <= frac_act_d;
            os_tick_q  <= os_tick_d;
            b_tick_q   <= b_tick_d;
            os_phase_q <= os_phase_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign b_tick   = b_tick_q;
    assign os_phase = os_phase_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_baud_gen_frac
//   Directed bench for baud_gen_frac. Main instance: DIV_W=8, FRAC_W=4, OSR=4.
//   A second instance with OSR=1 shares all inputs. Intervals are counted in
//   clock edges from one os_tick sample to the next; expected values are
//   worked out by hand from the divider arithmetic.
// -----------------------------------------------------------------------------
module tb_baud_gen_frac;

    localparam int DIV_W  = 8;
    localparam int FRAC_W = 4;
    localparam int OSR    = 4;

    logic              clk;
    logic              rst;
    logic              b_en;
    logic [DIV_W-1:0]  div_r;
    logic [FRAC_W-1:0] frac_r;
    logic              os_tick, b_tick;
    logic [1:0]        os_phase;
    logic              os_tick1, b_tick1;
    logic [0:0]        os_phase1;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    baud_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .b_en     (b_en),
        .DIVxR    (div_r),
        .FRACxR   (frac_r),
        .os_tick  (os_tick),
        .b_tick   (b_tick),
        .os_phase (os_phase)
    );

    baud_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(1)) u_dut_osr1 (
        .clk      (clk),
        .rst      (rst),
        .b_en     (b_en),
        .DIVxR    (div_r),
        .FRACxR   (frac_r),
        .os_tick  (os_tick1),
        .b_tick   (b_tick1),
        .os_phase (os_phase1)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so registered outputs are sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until os_tick is seen high; -1 when the bound expires.
    task automatic next_tick(input int max_edges, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!os_tick && edges < max_edges);
        if (!os_tick) edges = -1;
    endtask

    // Drop b_en for one edge (loads divisors, clears state), then re-enable.
    task automatic restart(input logic [DIV_W-1:0] d, input logic [FRAC_W-1:0] f);
        div_r  = d;
        frac_r = f;
        b_en   = 1'b0;
        tick();
        check("restart_os_tick", {31'd0, os_tick}, 32'd0);
        b_en = 1'b1;
    endtask

    // Integer divide-by-4 run with OSR=4: phases 0,1,2,3,0,... b_tick on 3.
    task automatic run_div4(input string tag, input int n);
        int e;
        for (int k = 0; k < n; k++) begin
            next_tick(64, e);
            check({tag, "_interval"}, e, 32'd4);
            check({tag, "_phase"}, {30'd0, os_phase}, k % 4);
            check({tag, "_b_tick"}, {31'd0, b_tick}, (k % 4 == 3) ? 32'd1 : 32'd0);
            check({tag, "_osr1_b_tick"}, {31'd0, b_tick1}, 32'd1);
            check({tag, "_osr1_phase"}, {31'd0, os_phase1}, 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e;
        int sum;
        int t3_exp[8];
        int max_exp[3];

        t3_exp  = '{1, 1, 1, 2, 1, 2, 1, 2};
        max_exp = '{256, 256, 257};

        rst    = 1'b0;
        b_en   = 1'b1;
        div_r  = 8'd3;
        frac_r = 4'd0;
        repeat (3) tick();
        // Reset dominates b_en.
        check("rst_os_tick", {31'd0, os_tick}, 32'd0);
        check("rst_b_tick", {31'd0, b_tick}, 32'd0);
        check("rst_os_phase", {30'd0, os_phase}, 32'd0);

        rst  = 1'b1;
        b_en = 1'b0;
        tick();
        check("dis_os_tick", {31'd0, os_tick}, 32'd0);

        // T1: integer divider, first tick after edge E3.
        b_en = 1'b1;
        run_div4("t1", 6);

        // T2: DIVxR=3, FRACxR=8 -> 4,4,5,4,5,... ; 16 intervals sum to 72.
        restart(8'd3, 4'd8);
        next_tick(64, e);
        check("t2_first", e, 32'd4);
        sum = 0;
        for (int k = 0; k < 16; k++) begin
            next_tick(64, e);
            if (k < 4) check("t2_interval", e, (k % 2 == 0) ? 32'd4 : 32'd5);
            sum += e;
        end
        check("t2_sum16", sum, 32'd72);

        // T3: DIVxR=0, FRACxR=0 -> os_tick high every cycle.
        restart(8'd0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_const_high", {31'd0, os_tick}, 32'd1);
        end
        // New fraction loads at the next wrap and is first added one wrap
        // later; the carry appears after the accumulator reaches 16.
        frac_r = 4'd8;
        for (int k = 0; k < 8; k++) begin
            next_tick(16, e);
            check("t3_frac_interval", e, t3_exp[k]);
        end

        // T4: divisor change mid-period does not alter the running period.
        restart(8'd3, 4'd0);
        next_tick(64, e);
        check("t4_first", e, 32'd4);
        tick();
        check("t4_mid_low", {31'd0, os_tick}, 32'd0);
        tick();
        div_r = 8'd7;
        next_tick(64, e);
        check("t4_rest_of_old", e, 32'd2);
        next_tick(64, e);
        check("t4_new_period", e, 32'd8);
        next_tick(64, e);
        check("t4_new_period2", e, 32'd8);

        // T5: one-edge reset mid-run, os_phase was nonzero beforehand.
        restart(8'd3, 4'd0);
        for (int k = 0; k < 3; k++) next_tick(64, e);
        check("t5_pre_phase", {30'd0, os_phase}, 32'd2);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_rst_os_tick", {31'd0, os_tick}, 32'd0);
        check("t5_rst_b_tick", {31'd0, b_tick}, 32'd0);
        check("t5_rst_os_phase", {30'd0, os_phase}, 32'd0);
        // Reset cleared the active divisor to 0, so the first period after
        // release is a single cycle; DIVxR is loaded at that wrap.
        next_tick(64, e);
        check("t5_first", e, 32'd1);
        check("t5_first_phase", {30'd0, os_phase}, 32'd0);
        next_tick(64, e);
        check("t5_second", e, 32'd4);
        check("t5_second_phase", {30'd0, os_phase}, 32'd1);

        // T6: b_en low 2 cycles mid-period -> no tick, clean restart.
        restart(8'd3, 4'd0);
        next_tick(64, e);
        tick();
        b_en = 1'b0;
        tick();
        check("t6_hold_low0", {31'd0, os_tick}, 32'd0);
        tick();
        check("t6_hold_low1", {31'd0, os_tick}, 32'd0);
        check("t6_hold_phase", {30'd0, os_phase}, 32'd0);
        b_en = 1'b1;
        run_div4("t6", 5);

        // DIVxR at max with carry: limit reaches 2^DIV_W.
        restart(8'd255, 4'd15);
        for (int k = 0; k < 3; k++) begin
            next_tick(400, e);
            check("max_interval", e, max_exp[k]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
